// File: rtl/scytale_codec.sv
// rtl/scytale_codec.sv - buffered scytale encrypt/decrypt codec with valid/ready output
// Optional build macro SCYTALE_PAD_EN: pad the message to a full matrix with PAD_CHAR.
module scytale_codec #(
    parameter int                 D_WIDTH       = 8,
    parameter int                 KEY_WIDTH     = 8,
    parameter int                 MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0] START_TOKEN   = 8'hFA,
    parameter logic [D_WIDTH-1:0] PAD_CHAR      = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic                 mode_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    input  logic                 ready_i,
    output logic                 busy,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 overflow_o
);

    localparam int IDX_W = $clog2(MAX_NOF_CHARS + 1);
    localparam int IW    = IDX_W + KEY_WIDTH;
    localparam int AW    = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(MAX_NOF_CHARS);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    state_t               r_state;
    logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];
    logic [IDX_W-1:0]     r_count;
    logic [IW-1:0]        r_stride;
    logic [IW-1:0]        r_len;
    logic [IW-1:0]        r_j;
    logic [IW-1:0]        r_k;
    logic                 r_busy;
    logic [D_WIDTH-1:0]   r_data;
    logic                 r_valid;
    logic                 r_done;
    logic                 r_error;
    logic                 r_overflow;

    logic [KEY_WIDTH-1:0] w_key;
    logic [IW-1:0]        w_stride;
    logic [IW-1:0]        w_count;
    logic [IW-1:0]        w_len;
    logic                 w_is_token;
    logic                 w_key_bad;
    logic [IW-1:0]        w_k_adv;
    logic [IW-1:0]        w_j_adv;
    logic                 w_wrap;
    logic                 w_last;
    logic [IW-1:0]        w_next_idx;
    logic [D_WIDTH-1:0]   w_next_char;

    assign w_key      = mode_i ? key_M : key_N;
    assign w_stride   = IW'(w_key);
    assign w_count    = IW'(r_count);
    assign w_is_token = (data_i == START_TOKEN);

`ifdef SCYTALE_PAD_EN
    logic [IW-1:0] w_div;
    // Divisor forced non-zero; a zero key is rejected before the length is used.
    assign w_div       = (w_stride == '0) ? IW'(1) : w_stride;
    assign w_len       = ((w_count + w_div - IW'(1)) / w_div) * w_div;
    assign w_next_char = (w_next_idx >= w_count) ? PAD_CHAR : r_buf[w_next_idx[AW-1:0]];
`else
    assign w_len       = w_count;
    assign w_next_char = r_buf[w_next_idx[AW-1:0]];
`endif

    assign w_key_bad  = (w_stride == '0) || ((w_len != '0) && (w_stride > w_len));

    // Walk one column (step by stride); on running off the end restart at the next column.
    assign w_k_adv    = r_k + r_stride;
    assign w_j_adv    = r_j + IW'(1);
    assign w_wrap     = (w_k_adv >= r_len);
    assign w_last     = w_wrap && (w_j_adv == r_stride);
    assign w_next_idx = w_wrap ? w_j_adv : w_k_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_COLLECT;
            r_count    <= '0;
            r_stride   <= '0;
            r_len      <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (valid_i) begin
                        if (!w_is_token) begin
                            if (r_count == MAX_CNT) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_buf[r_count[AW-1:0]] <= data_i;
                                r_count                <= r_count + 1'b1;
                            end
                        end else if (w_key_bad) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_count <= '0;
                            for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                                r_buf[i] <= '0;
                            end
                        end else if (w_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_stride <= w_stride;
                            r_len    <= w_len;
                            r_j      <= '0;
                            r_k      <= '0;
                            r_data   <= r_buf[0];
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b1;
                            r_state  <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (ready_i) begin
                        if (w_last) begin
                            r_valid    <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                            r_j        <= '0;
                            r_k        <= '0;
                            r_state    <= S_COLLECT;
                            for (int i = 0; i < MAX_NOF_CHARS; i++) begin
                                r_buf[i] <= '0;
                            end
                        end else begin
                            if (w_wrap) begin
                                r_j <= w_j_adv;
                            end
                            r_k    <= w_next_idx;
                            r_data <= w_next_char;
                        end
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign busy       = r_busy;
    assign data_o     = r_data;
    assign valid_o    = r_valid;
    assign done_o     = r_done;
    assign error_o    = r_error;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_scytale_codec.sv
// tb/tb_scytale_codec.sv - self-checking bench for scytale_codec (default depth and depth 4)
`timescale 1ns/1ps
module tb_scytale_codec;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic       mode_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic       ready_i;

    logic [1:0] busy_w, valid_w, done_w, error_w, ovf_w;
    logic [7:0] data_w [2];

    always #5 clk = ~clk;

    scytale_codec dut_big (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .mode_i(mode_i),
        .key_N(key_N), .key_M(key_M), .ready_i(ready_i), .busy(busy_w[0]),
        .data_o(data_w[0]), .valid_o(valid_w[0]), .done_o(done_w[0]),
        .error_o(error_w[0]), .overflow_o(ovf_w[0])
    );

    scytale_codec #(.MAX_NOF_CHARS(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i), .mode_i(mode_i),
        .key_N(key_N), .key_M(key_M), .ready_i(ready_i), .busy(busy_w[1]),
        .data_o(data_w[1]), .valid_o(valid_w[1]), .done_o(done_w[1]),
        .error_o(error_w[1]), .overflow_o(ovf_w[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int tok    = 0;
    bit started = 1'b0;

    // Reference model state, one slot per instance.
    logic [7:0] bmem [2][64];
    int         bsz  [2];
    bit         m_ovf [2];
    logic [7:0] emem [2][64];
    int         ehd  [2];
    int         etl  [2];
    bit         m_emit [2];
    bit         m_done [2];
    bit         m_err  [2];

    logic [7:0] cap [2][64];
    int         caplen   [2];
    int         err_cnt  [2];
    int         done_cyc [2];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic int depth(input int m);
        return (m == 0) ? 50 : 4;
    endfunction

    task automatic model_step(input int m);
        int s, l;
        bit dn, er;
        dn = 1'b0;
        er = 1'b0;
        if (!rst_n) begin
            bsz[m] = 0; m_ovf[m] = 1'b0; m_emit[m] = 1'b0; ehd[m] = 0; etl[m] = 0;
        end else if (m_emit[m]) begin
            if (ready_i) begin
                ehd[m] = ehd[m] + 1;
                if (ehd[m] == etl[m]) begin
                    m_emit[m] = 1'b0; dn = 1'b1; bsz[m] = 0; m_ovf[m] = 1'b0;
                end
            end
        end else if (valid_i) begin
            if (data_i != 8'hFA) begin
                if (bsz[m] < depth(m)) begin
                    bmem[m][bsz[m]] = data_i;
                    bsz[m] = bsz[m] + 1;
                end else begin
                    m_ovf[m] = 1'b1;
                end
            end else begin
                s = mode_i ? int'(key_M) : int'(key_N);
                l = bsz[m];
                if (s == 0 || (l > 0 && s > l)) begin
                    er = 1'b1; dn = 1'b1; bsz[m] = 0;
                end else if (l == 0) begin
                    dn = 1'b1;
                end else begin
                    ehd[m] = 0;
                    etl[m] = 0;
                    for (int j = 0; j < s; j++) begin
                        for (int k = j; k < l; k += s) begin
                            emem[m][etl[m]] = bmem[m][k];
                            etl[m] = etl[m] + 1;
                        end
                    end
                    m_emit[m] = 1'b1;
                end
            end
        end
        m_done[m] = dn;
        m_err[m]  = er;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) started = 1'b1;
        for (int m = 0; m < 2; m++) begin
            if (started && rst_n && valid_w[m] && ready_i) begin
                cap[m][caplen[m]] = data_w[m];
                caplen[m] = caplen[m] + 1;
            end
            model_step(m);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("busy[%0d]", m), 32'(busy_w[m]), 32'(m_emit[m]));
                chk($sformatf("valid[%0d]", m), 32'(valid_w[m]), 32'(m_emit[m]));
                if (m_emit[m]) chk($sformatf("data[%0d]", m), 32'(data_w[m]), 32'(emem[m][ehd[m]]));
                chk($sformatf("done[%0d]", m), 32'(done_w[m]), 32'(m_done[m]));
                chk($sformatf("error[%0d]", m), 32'(error_w[m]), 32'(m_err[m]));
                chk($sformatf("overflow[%0d]", m), 32'(ovf_w[m]), 32'(m_ovf[m]));
                if (done_w[m] === 1'b1) done_cyc[m] = cyc;
                if (error_w[m] === 1'b1) err_cnt[m] = err_cnt[m] + 1;
            end
        end
    end

    task automatic begin_msg();
        for (int m = 0; m < 2; m++) begin
            caplen[m] = 0; err_cnt[m] = 0; done_cyc[m] = -1;
        end
    endtask

    task automatic push(input logic [7:0] c);
        data_i  = c;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) push(s[i]);
    endtask

    task automatic send_tok(input logic md, input logic [7:0] n, input logic [7:0] mm);
        mode_i  = md;
        key_N   = n;
        key_M   = mm;
        data_i  = 8'hFA;
        valid_i = 1'b1;
        @(negedge clk);
        tok     = cyc;
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle, input bit gap);
        int i;
        for (i = 0; i < 300; i++) begin
            if (busy_w === 2'b00) break;
            if (toggle) ready_i = ~ready_i;
            @(negedge clk);
        end
        if (i == 300) chk("idle_timeout", 32'(busy_w), 32'd0);
        ready_i = 1'b1;
        if (gap) @(negedge clk);
    endtask

    task automatic chk_cap(input int m, input string exp, input string name);
        chk({name, "_len"}, 32'(caplen[m]), 32'(exp.len()));
        for (int k = 0; k < exp.len() && k < caplen[m]; k++)
            chk($sformatf("%s[%0d]", name, k), 32'(cap[m][k]), 32'(exp[k]));
    endtask

    task automatic chk_idle_zero(input string name);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s_busy%0d", name, m), 32'(busy_w[m]), 32'd0);
            chk($sformatf("%s_data%0d", name, m), 32'(data_w[m]), 32'd0);
            chk($sformatf("%s_valid%0d", name, m), 32'(valid_w[m]), 32'd0);
            chk($sformatf("%s_done%0d", name, m), 32'(done_w[m]), 32'd0);
            chk($sformatf("%s_error%0d", name, m), 32'(error_w[m]), 32'd0);
            chk($sformatf("%s_ovf%0d", name, m), 32'(ovf_w[m]), 32'd0);
        end
    endtask

    initial begin
        int i;
        rst_n = 1'b0; data_i = 8'h00; valid_i = 1'b0; mode_i = 1'b0;
        key_N = 8'd0; key_M = 8'd0; ready_i = 1'b1;
        begin_msg();
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;

        // Decrypt, full matrix; done lands L cycles after the token edge.
        begin_msg();
        push_str("ACEBDF");
        send_tok(1'b0, 8'd3, 8'd2);
        wait_idle(1'b0, 1'b1);
        chk_cap(0, "ABCDEF", "dec_big");
        chk_cap(1, "ABCE", "dec_small");
        chk("dec_done_latency", 32'(done_cyc[0] - tok), 32'd6);

        // Encrypt uses key_M even though key_N differs.
        begin_msg();
        push_str("ABCDEF");
        send_tok(1'b1, 8'd3, 8'd2);
        wait_idle(1'b0, 1'b0);
        chk_cap(0, "ACEBDF", "enc_big");
        chk_cap(1, "ACBD", "enc_small");

        // Back-to-back with the previous done, ready toggling.
        begin_msg();
        push_str("ABCDEF");
        send_tok(1'b1, 8'd3, 8'd2);
        wait_idle(1'b1, 1'b0);
        chk_cap(0, "ACEBDF", "stall_big");
        chk_cap(1, "ACBD", "stall_small");

        begin_msg();
        push_str("ABCDE");
        send_tok(1'b0, 8'd3, 8'd2);
        wait_idle(1'b0, 1'b0);
        chk_cap(0, "ADBEC", "ragged_big");
        chk_cap(1, "ADBC", "ragged_small");

        begin_msg();
        push_str("AB");
        send_tok(1'b0, 8'd0, 8'd2);
        wait_idle(1'b0, 1'b1);
        chk("key0_err", 32'(err_cnt[0]), 32'd1);
        chk("key0_err_s", 32'(err_cnt[1]), 32'd1);
        chk("key0_nout", 32'(caplen[0] + caplen[1]), 32'd0);
        chk("key0_done_at", 32'(done_cyc[0] - tok), 32'd0);

        begin_msg();
        push_str("AB");
        send_tok(1'b0, 8'd5, 8'd2);
        wait_idle(1'b0, 1'b1);
        chk("key5_err", 32'(err_cnt[0]), 32'd1);
        chk("key5_err_s", 32'(err_cnt[1]), 32'd1);
        chk("key5_nout", 32'(caplen[0] + caplen[1]), 32'd0);

        begin_msg();
        push_str("AB");
        send_tok(1'b0, 8'd1, 8'd2);
        wait_idle(1'b0, 1'b0);
        chk_cap(0, "AB", "key1_big");
        chk_cap(1, "AB", "key1_small");

        begin_msg();
        push_str("ABCD");
        chk("ovf_after4", 32'(ovf_w[1]), 32'd0);
        push("E");
        chk("ovf_after5", 32'(ovf_w[1]), 32'd1);
        chk("ovf_big_after5", 32'(ovf_w[0]), 32'd0);
        push("F");
        send_tok(1'b0, 8'd2, 8'd2);
        wait_idle(1'b0, 1'b1);
        chk_cap(0, "ACEBDF", "ovf_big");
        chk_cap(1, "ACBD", "ovf_small");
        chk("ovf_cleared", 32'(ovf_w[1]), 32'd0);

        // Reset in the middle of replay, then a fresh message.
        begin_msg();
        push_str("ABCDEF");
        send_tok(1'b0, 8'd1, 8'd2);
        for (i = 0; i < 50; i++) begin
            if (caplen[0] >= 2) break;
            @(negedge clk);
        end
        if (i == 50) chk("rst_wait_timeout", 32'(caplen[0]), 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_zero("midrst");
        rst_n = 1'b1;
        begin_msg();
        push_str("ABC");
        send_tok(1'b0, 8'd2, 8'd2);
        wait_idle(1'b0, 1'b1);
        chk_cap(0, "ACB", "post_big");
        chk_cap(1, "ACB", "post_small");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scytale_codec.md
# scytale_codec

Parametrised successor to the single-mode scytale decryptor, in the same decryption datapath. It buffers up to MAX_NOF_CHARS characters and replays them in scytale order when START_TOKEN arrives, either decrypting (stride key_N) or encrypting (stride key_M) as selected per message. Output uses a valid/ready handshake so downstream can stall. Key errors and buffer overflow are reported instead of producing garbage.

## Interface
- D_WIDTH, 8, character width
- KEY_WIDTH, 8, width of key_N / key_M
- MAX_NOF_CHARS, 50, buffer depth in characters
- START_TOKEN, 8'hFA, character that ends collection and starts replay
- PAD_CHAR, 8'h00, fill character (used only with SCYTALE_PAD_EN)
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- data_i  in  D_WIDTH  input character
- valid_i  in  1  data_i qualifier
- mode_i  in  1  0 = decrypt (stride key_N), 1 = encrypt (stride key_M); sampled with START_TOKEN
- key_N  in  KEY_WIDTH  matrix columns; sampled with START_TOKEN
- key_M  in  KEY_WIDTH  matrix rows; sampled with START_TOKEN
- ready_i  in  1  downstream accepts data_o this cycle
- busy  out  1  replay in progress; valid_i ignored while high
- data_o  out  D_WIDTH  output character
- valid_o  out  1  data_o qualifier
- done_o  out  1  one-cycle pulse: message finished (or rejected)
- error_o  out  1  one-cycle pulse: key rejected
- overflow_o  out  1  sticky: a character was dropped for lack of space

## Operation
- States: COLLECT (reset state), EMIT.
- COLLECT: on valid_i with data_i != START_TOKEN, store at index count, count++. If count == MAX_NOF_CHARS, drop the character and set overflow_o.
- COLLECT, valid_i with START_TOKEN: latch mode, S = mode ? key_M : key_N, and L = count (padded; see Configuration).
  - If S == 0 or S > L (with L > 0): pulse error_o and done_o, clear buffer/count, stay in COLLECT.
  - If L == 0: pulse done_o, stay in COLLECT.
  - Otherwise: j = 0, k = 0, go to EMIT.
- EMIT order: for j = 0..S-1, for k = j; k < L; k += S, emit buf[k].
  - Each character is held on data_o with valid_o = 1 until the cycle ready_i = 1.
  - In that cycle advance k; if k + S >= L, set j++ and k = j.
  - When j reaches S: valid_o = 0, pulse done_o, clear buffer, count, overflow_o and indices, then go to COLLECT.
- Index arithmetic uses IDX_W + KEY_WIDTH bits, where IDX_W = $clog2(MAX_NOF_CHARS+1); k + S never wraps.
- valid_i during EMIT is ignored; it is neither stored nor counted.

## Timing
- Reset values: busy=0, data_o=0, valid_o=0, done_o=0, error_o=0, overflow_o=0. count, j, k and buffer are cleared.
- rst_n low mid-EMIT aborts on that edge. No done_o is produced.
- Token accepted at edge T: busy=1 and valid_o=1 with the first character (buf[0]) from T+1.
- With ready_i held high, one character per cycle: the L characters occupy T+1 .. T+L.
- done_o is asserted in the cycle after the last handshake; busy falls in the same cycle.
- Back-to-back: the first character of the next message is accepted in the cycle done_o is high.
- Error or empty token at T: error_o/done_o high in T+1 only; busy stays 0.
- ready_i low: data_o and valid_o are stable, no index advance.

## Configuration
- SCYTALE_PAD_EN defined: on token, L = ceil(count/S)*S, computed after the S == 0 check. Positions >= count emit PAD_CHAR, so every message outputs a full matrix.
- Not defined: L = count, and positions >= count are skipped (ragged last column).

## Test plan
- Decrypt, N=3, M=2, input "ACEBDF"+FA, ready_i=1 -> outputs A,B,C,D,E,F on consecutive cycles T+1..T+6; done_o at T+7.
- Encrypt, mode_i=1, M=2, input "ABCDEF"+FA -> outputs A,C,E,B,D,F. Toggle ready_i 1/0 -> same sequence, each character held while stalled.
- Ragged, N=3, input "ABCDE"+FA:
  - Without the macro -> A,D,B,E,C.
  - With SCYTALE_PAD_EN and PAD_CHAR=00 -> A,D,B,E,C,00.
- Key errors:
  - key_N=0, "AB"+FA -> error_o and done_o pulse, no valid_o.
  - key_N=5, "AB"+FA -> same.
  - A following "AB"+FA with key_N=1 -> A,B.
- Overflow, MAX_NOF_CHARS=4, input "ABCDEF"+FA with N=2 -> overflow_o=1 after the 5th character; output A,C,B,D; overflow_o cleared with done_o.
- Reset mid-EMIT after the 2nd output -> all outputs 0 next cycle. A new message then decodes correctly from an empty buffer.
